// File: rtl/ame_solver_arbiter_pkg.sv
// Shared types and constants for the affine-ME solver arbiter.
package ame_solver_pkg;

  localparam int SOLVER_ROWS = 6;
  localparam int SOLVER_COLS = 7;

  // Default-width response record; the top builds a width-parameterised twin.
  localparam int RSP_ID_BITS_DEF   = 2;
  localparam int RSP_DATA_BITS_DEF = 64;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef struct packed {
    logic [RSP_ID_BITS_DEF-1:0]                    id;
    logic                                          param6;
    logic [SOLVER_ROWS-1:0][RSP_DATA_BITS_DEF-1:0] data;
  } rsp_t;

  // Wrap an index that is known to be below 2*n back into 0..n-1.
  function automatic int rr_wrap(input int v, input int n);
    return (v >= n) ? (v - n) : v;
  endfunction

endpackage

// File: rtl/ame_solver_arbiter_if.sv
// Request / solver / response bundle of the solver arbiter.
// slave = arbiter side, master = requesters + solver + consumer side.
interface ame_solver_arbiter_if #(
  parameter int NUM_REQ        = 4,
  parameter int COMP_DATA_BITS = 64,
  parameter int REQ_ID_BITS    = $clog2(NUM_REQ)
);
  import ame_solver_pkg::*;

  logic [NUM_REQ-1:0]                                               req_valid_i;
  logic [NUM_REQ-1:0]                                               req_ready_o;
  logic [NUM_REQ-1:0]                                               req_param6_i;
  logic [NUM_REQ-1:0][SOLVER_ROWS-1:0][SOLVER_COLS-1:0][COMP_DATA_BITS-1:0] req_data_i;

  logic                                                  slv_init_o;
  logic                                                  slv_param6_o;
  logic [SOLVER_ROWS-1:0][SOLVER_COLS-1:0][COMP_DATA_BITS-1:0] slv_data_o;
  logic                                                  slv_done_i;
  logic [SOLVER_ROWS-1:0][COMP_DATA_BITS-1:0]            slv_data_i;

  logic                                       rsp_valid_o;
  logic                                       rsp_ready_i;
  logic [REQ_ID_BITS-1:0]                     rsp_id_o;
  logic                                       rsp_param6_o;
  logic [SOLVER_ROWS-1:0][COMP_DATA_BITS-1:0] rsp_data_o;

  modport slave (
    input  req_valid_i, req_param6_i, req_data_i, slv_done_i, slv_data_i, rsp_ready_i,
    output req_ready_o, slv_init_o, slv_param6_o, slv_data_o,
           rsp_valid_o, rsp_id_o, rsp_param6_o, rsp_data_o
  );

  modport master (
    output req_valid_i, req_param6_i, req_data_i, slv_done_i, slv_data_i, rsp_ready_i,
    input  req_ready_o, slv_init_o, slv_param6_o, slv_data_o,
           rsp_valid_o, rsp_id_o, rsp_param6_o, rsp_data_o
  );

endinterface

// File: rtl/ame_solver_arbiter_rr.sv
// Combinational round-robin picker: first valid requester at or after ptr_i.
// nxt_ptr_o is what the owner's pointer register should load this cycle.
module ame_rr_arbiter import ame_solver_pkg::*; #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          adv_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic [IW-1:0] nxt_ptr_o
);

  // Scan N positions starting at the pointer; the first hit wins.
  always_comb begin
    logic          found;
    logic [IW-1:0] cand;
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'(rr_wrap(int'(ptr_i) + i, N));
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

  assign nxt_ptr_o = !adv_i                ? ptr_i :
                     (idx_o == IW'(N - 1)) ? '0    : idx_o + 1'b1;

endmodule

// File: rtl/ame_solver_arbiter.sv
// Shares one ame_equation_solver between NUM_REQ affine-ME requesters.
// Round-robin grant, latch matrix/mode/id, pulse comp_init, capture results on
// comp_done and return them over a valid/ready response port.
// Optional: AME_SOLVER_RSP_FIFO_EN adds a 2-entry response FIFO so the next
// solve can launch while an earlier response is still waiting.
module ame_solver_arbiter import ame_solver_pkg::*; #(
  parameter int NUM_REQ        = 4,
  parameter int COMP_DATA_BITS = 64,
  parameter int REQ_ID_BITS    = $clog2(NUM_REQ)
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  ame_solver_arbiter_if.slave bus
);

  typedef logic [SOLVER_ROWS-1:0][SOLVER_COLS-1:0][COMP_DATA_BITS-1:0] mat_t;
  typedef logic [SOLVER_ROWS-1:0][COMP_DATA_BITS-1:0]                  vec_t;
  typedef struct packed {
    logic [REQ_ID_BITS-1:0] id;
    logic                   param6;
    vec_t                   data;
  } rsp_w_t;

  state_t                 r_state;
  logic                   r_init;
  mat_t                   r_mat;
  logic                   r_param6;
  logic [REQ_ID_BITS-1:0] r_id;
  logic [REQ_ID_BITS-1:0] r_ptr;

  logic [NUM_REQ-1:0]     w_gnt;
  logic [NUM_REQ-1:0]     w_ready;
  logic [REQ_ID_BITS-1:0] w_idx;
  logic [REQ_ID_BITS-1:0] w_nxt_ptr;
  logic                   w_can_grant;
  logic                   w_xfer;
  logic                   w_done;
  rsp_w_t                 w_new;

  ame_rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req_i     (bus.req_valid_i),
    .ptr_i     (r_ptr),
    .adv_i     (w_xfer),
    .gnt_o     (w_gnt),
    .idx_o     (w_idx),
    .nxt_ptr_o (w_nxt_ptr)
  );

`ifdef AME_SOLVER_RSP_FIFO_EN
  rsp_w_t     r_q [2];
  logic [1:0] r_cnt;
  logic       w_pop;

  assign w_can_grant = (r_state == IDLE) && (r_cnt != 2'd2);
`else
  rsp_w_t r_res;
  logic   r_rsp_valid;

  assign w_can_grant = (r_state == IDLE);
`endif

  assign w_ready = w_can_grant ? w_gnt : '0;
  assign w_xfer  = |(bus.req_valid_i & w_ready);
  assign w_done  = (r_state == WAIT) && bus.slv_done_i;
  assign w_new   = {r_id, r_param6, bus.slv_data_i};

  // Main sequencer: grant/latch, one-cycle init pulse, wait for done, respond.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= IDLE;
      r_init      <= 1'b0;
      r_mat       <= '0;
      r_param6    <= 1'b0;
      r_id        <= '0;
      r_ptr       <= '0;
`ifndef AME_SOLVER_RSP_FIFO_EN
      r_res       <= '0;
      r_rsp_valid <= 1'b0;
`endif
    end else begin
      r_ptr <= w_nxt_ptr;
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_mat    <= bus.req_data_i[w_idx];
            r_param6 <= bus.req_param6_i[w_idx];
            r_id     <= w_idx;
            r_state  <= LAUNCH;
          end
        end
        LAUNCH: begin
          r_init  <= 1'b1;
          r_state <= WAIT;
        end
        WAIT: begin
          r_init <= 1'b0;
          if (w_done) begin
`ifdef AME_SOLVER_RSP_FIFO_EN
            r_state     <= IDLE;
`else
            r_res       <= w_new;
            r_rsp_valid <= 1'b1;
            r_state     <= RESP;
`endif
          end
        end
        RESP: begin
`ifdef AME_SOLVER_RSP_FIFO_EN
          r_state <= IDLE;
`else
          if (bus.rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= IDLE;
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef AME_SOLVER_RSP_FIFO_EN
  assign w_pop = (r_cnt != 2'd0) && bus.rsp_ready_i;

  // Two-entry response queue; entry 0 is always the head.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_q[0] <= '0;
      r_q[1] <= '0;
      r_cnt  <= 2'd0;
    end else begin
      case ({w_done, w_pop})
        2'b10: begin
          r_q[r_cnt[0]] <= w_new;
          r_cnt         <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_q[0] <= r_q[1];
          r_cnt  <= r_cnt - 2'd1;
        end
        // Push and pop together only happen at count 1: new entry becomes head.
        2'b11: r_q[0] <= w_new;
        default: ;
      endcase
    end
  end

  assign bus.rsp_valid_o  = (r_cnt != 2'd0);
  assign bus.rsp_id_o     = r_q[0].id;
  assign bus.rsp_param6_o = r_q[0].param6;
  assign bus.rsp_data_o   = r_q[0].data;
`else
  assign bus.rsp_valid_o  = r_rsp_valid;
  assign bus.rsp_id_o     = r_res.id;
  assign bus.rsp_param6_o = r_res.param6;
  assign bus.rsp_data_o   = r_res.data;
`endif

  assign bus.req_ready_o  = w_ready;
  assign bus.slv_init_o   = r_init;
  assign bus.slv_param6_o = r_param6;
  assign bus.slv_data_o   = r_mat;

endmodule
